// File: rtl/tia_horizontal_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : tia_horizontal_decode_pkg
// Desc   : Horizontal LFSR decode codes and the decoded-event type shared by
//          the horizontal decoder, the LFSR stage and the bench.
// Rev    : 1.0  initial release
// ============================================================================
package tia_horizontal_decode_pkg;

    localparam logic [5:0] DEF_SHS_CODE    = 6'b111100;  // count 4
    localparam logic [5:0] DEF_RHS_CODE    = 6'b110111;  // count 8
    localparam logic [5:0] DEF_RCB_CODE    = 6'b001111;  // count 12
    localparam logic [5:0] DEF_RHB_CODE    = 6'b011100;  // count 16
    localparam logic [5:0] DEF_LRHB_CODE   = 6'b010111;  // count 18
    localparam logic [5:0] DEF_CNT_CODE    = 6'b101100;  // count 36
    localparam logic [5:0] LOCKUP_CODE     = 6'b111111;  // LFSR lock-up state

    typedef enum logic [2:0] {
        HC_NONE = 3'd0,
        HC_SHS  = 3'd1,
        HC_RHS  = 3'd2,
        HC_RCB  = 3'd3,
        HC_RHB  = 3'd4,
        HC_LRHB = 3'd5,
        HC_CNT  = 3'd6,
        HC_LOCK = 3'd7
    } hcode_e;

endpackage
`default_nettype wire

// File: rtl/tia_sr_flop.sv
`default_nettype none
// ============================================================================
// Module : tia_sr_flop
// Desc   : Synchronous set/reset flop; reset > set > clear, holds otherwise.
// Rev    : 1.0  initial release
// ============================================================================
module tia_sr_flop #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_set) begin
            r_q <= 1'b1;
        end else if (i_clr) begin
            r_q <= 1'b0;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/tia_horizontal_decode.sv
`default_nettype none
// ============================================================================
// Module : tia_horizontal_decode
// Desc   : Decodes the horizontal LFSR count into HSYNC, HBLANK (with HMOVE
//          late blank), colour burst and centre pulse. Optional sticky lock-up
//          error flag when TIA_HDECODE_ERR_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module tia_horizontal_decode
    import tia_horizontal_decode_pkg::*;
#(
    parameter logic [5:0] SHS_CODE  = DEF_SHS_CODE,
    parameter logic [5:0] RHS_CODE  = DEF_RHS_CODE,
    parameter logic [5:0] RCB_CODE  = DEF_RCB_CODE,
    parameter logic [5:0] RHB_CODE  = DEF_RHB_CODE,
    parameter logic [5:0] LRHB_CODE = DEF_LRHB_CODE,
    parameter logic [5:0] CNT_CODE  = DEF_CNT_CODE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hphi_en,
    input  logic [5:0] lfsr,
    input  logic       shb,
    input  logic       hmove_strobe,
    output logic       hsync,
    output logic       hblank,
    output logic       cburst,
    output logic       center,
    output logic       line_start,
`ifdef TIA_HDECODE_ERR_EN
    output logic       err,
`endif
    output logic       hmove_latch
);

    hcode_e w_code;
    logic   w_line;
    logic   w_hsync_set, w_hsync_clr;
    logic   w_hblank_set, w_hblank_clr;
    logic   w_cburst_set, w_cburst_clr;
    logic   w_hmove_clr;
    logic   r_center;
    logic   r_line_start;

    // shb outranks any count match; no strobe means no event at all
    always_comb begin
        w_code = HC_NONE;
        if (hphi_en && !shb) begin
            if (lfsr == SHS_CODE)         w_code = HC_SHS;
            else if (lfsr == RHS_CODE)    w_code = HC_RHS;
            else if (lfsr == RCB_CODE)    w_code = HC_RCB;
            else if (lfsr == RHB_CODE)    w_code = HC_RHB;
            else if (lfsr == LRHB_CODE)   w_code = HC_LRHB;
            else if (lfsr == CNT_CODE)    w_code = HC_CNT;
            else if (lfsr == LOCKUP_CODE) w_code = HC_LOCK;
        end
    end

    assign w_line       = hphi_en && shb;
    assign w_hsync_set  = (w_code == HC_SHS);
    assign w_hsync_clr  = w_line || (w_code == HC_RHS);
    assign w_cburst_set = (w_code == HC_RHS);
    assign w_cburst_clr = w_line || (w_code == HC_RCB);
    assign w_hblank_set = w_line;
    // HMOVE pending moves the end of blank from RHB to the late LRHB count
    assign w_hblank_clr = ((w_code == HC_RHB)  && !hmove_latch) ||
                          ((w_code == HC_LRHB) &&  hmove_latch);
    assign w_hmove_clr  = (w_code == HC_LRHB);

    tia_sr_flop #(.RST_VAL(1'b0)) u_hsync (
        .clk   (clk),
        .rst   (reset),
        .i_set (w_hsync_set),
        .i_clr (w_hsync_clr),
        .o_q   (hsync)
    );

    tia_sr_flop #(.RST_VAL(1'b1)) u_hblank (
        .clk   (clk),
        .rst   (reset),
        .i_set (w_hblank_set),
        .i_clr (w_hblank_clr),
        .o_q   (hblank)
    );

    tia_sr_flop #(.RST_VAL(1'b0)) u_cburst (
        .clk   (clk),
        .rst   (reset),
        .i_set (w_cburst_set),
        .i_clr (w_cburst_clr),
        .o_q   (cburst)
    );

    tia_sr_flop #(.RST_VAL(1'b0)) u_hmove (
        .clk   (clk),
        .rst   (reset),
        .i_set (hmove_strobe),
        .i_clr (w_hmove_clr),
        .o_q   (hmove_latch)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_center     <= 1'b0;
            r_line_start <= 1'b0;
        end else begin
            r_center     <= (w_code == HC_CNT);
            r_line_start <= w_line;
        end
    end

    assign center     = r_center;
    assign line_start = r_line_start;

`ifdef TIA_HDECODE_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_code == HC_LOCK) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tia_horizontal_decode.sv
`default_nettype none
// ============================================================================
// Module : tb_tia_horizontal_decode
// Desc   : Directed self-checking bench with an expected-value scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tia_horizontal_decode;
    import tia_horizontal_decode_pkg::*;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic cburst;
        logic center;
        logic line_start;
        logic hmove_latch;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       hphi_en;
    logic [5:0] lfsr;
    logic       shb;
    logic       hmove_strobe;
    logic       hsync, hblank, cburst, center, line_start, hmove_latch;
    logic       err_obs;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t m;      // reference model state
    exp_t e;

    always #5 clk = ~clk;

    tia_horizontal_decode dut (
        .clk          (clk),
        .reset        (reset),
        .hphi_en      (hphi_en),
        .lfsr         (lfsr),
        .shb          (shb),
        .hmove_strobe (hmove_strobe),
        .hsync        (hsync),
        .hblank       (hblank),
        .cburst       (cburst),
        .center       (center),
        .line_start   (line_start),
`ifdef TIA_HDECODE_ERR_EN
        .err          (err_obs),
`endif
        .hmove_latch  (hmove_latch)
    );

`ifndef TIA_HDECODE_ERR_EN
    assign err_obs = 1'b0;
`endif

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model of one clock, written from the behavioural description
    task automatic model(input logic r, input logic h, input logic [5:0] c,
                         input logic s, input logic hm);
        logic old_latch;
        if (r) begin
            m = '{hsync:1'b0, hblank:1'b1, cburst:1'b0, center:1'b0,
                  line_start:1'b0, hmove_latch:1'b0, err:1'b0};
            return;
        end
        old_latch    = m.hmove_latch;
        m.center     = 1'b0;
        m.line_start = 1'b0;
        if (h && s) begin
            m.hblank = 1'b1; m.hsync = 1'b0; m.cburst = 1'b0; m.line_start = 1'b1;
        end else if (h) begin
            case (c)
                DEF_SHS_CODE: m.hsync = 1'b1;
                DEF_RHS_CODE: begin m.hsync = 1'b0; m.cburst = 1'b1; end
                DEF_RCB_CODE: m.cburst = 1'b0;
                DEF_RHB_CODE: if (!old_latch) m.hblank = 1'b0;
                DEF_LRHB_CODE: begin
                    if (old_latch) m.hblank = 1'b0;
                    m.hmove_latch = 1'b0;
                end
                DEF_CNT_CODE: m.center = 1'b1;
                LOCKUP_CODE: begin
`ifdef TIA_HDECODE_ERR_EN
                    m.err = 1'b1;
`endif
                end
                default: ;
            endcase
        end
        if (hm) m.hmove_latch = 1'b1;
    endtask

    task automatic step(input logic r, input logic h, input logic [5:0] c,
                        input logic s, input logic hm, input string tag);
        @(negedge clk);
        reset = r; hphi_en = h; lfsr = c; shb = s; hmove_strobe = hm;
        model(r, h, c, s, hm);
        q.push_back(m);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            check({tag, ".hsync"},       hsync,       e.hsync);
            check({tag, ".hblank"},      hblank,      e.hblank);
            check({tag, ".cburst"},      cburst,      e.cburst);
            check({tag, ".center"},      center,      e.center);
            check({tag, ".line_start"},  line_start,  e.line_start);
            check({tag, ".hmove_latch"}, hmove_latch, e.hmove_latch);
            check({tag, ".err"},         err_obs,     e.err);
        end
    endtask

    task automatic strobe(input logic [5:0] c, input string tag);
        step(1'b0, 1'b1, c, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'h00, 1'b0, 1'b0, tag);
    endtask

    task automatic line_begin(input string tag);
        step(1'b0, 1'b1, 6'h15, 1'b1, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1; hphi_en = 1'b0; lfsr = 6'h00; shb = 1'b0; hmove_strobe = 1'b0;
        m = '0;

        // Reset and quiet period
        step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, "reset");
        step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, "reset2");
        idle(20, "quiet");

        // Normal line (shb outranks the code on lfsr)
        line_begin("shb");
        idle(3, "gap");
        strobe(DEF_SHS_CODE, "shs");
        idle(3, "sync");
        strobe(DEF_RHS_CODE, "rhs");
        strobe(DEF_RCB_CODE, "rcb");
        strobe(6'h2a, "nocode");
        strobe(DEF_RHB_CODE, "rhb");
        strobe(DEF_LRHB_CODE, "lrhb_nolatch");
        strobe(DEF_CNT_CODE, "cnt");
        idle(2, "post_cnt");

        // HMOVE: blank held past RHB until LRHB
        line_begin("shb2");
        strobe(DEF_SHS_CODE, "shs2");
        strobe(DEF_RHS_CODE, "rhs2");
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1, "hmove");
        strobe(DEF_RCB_CODE, "rcb2");
        strobe(DEF_RHB_CODE, "rhb_latched");
        strobe(DEF_LRHB_CODE, "lrhb_latched");
        idle(2, "post_lrhb");

        // HMOVE write coinciding with LRHB keeps the latch for the next line
        line_begin("shb3");
        step(1'b0, 1'b0, 6'h00, 1'b0, 1'b1, "hmove3");
        strobe(DEF_RHB_CODE, "rhb3");
        step(1'b0, 1'b1, DEF_LRHB_CODE, 1'b0, 1'b1, "lrhb_and_hmove");
        line_begin("shb4");
        strobe(DEF_SHS_CODE, "shs4");
        strobe(DEF_RHB_CODE, "rhb4_held");
        strobe(DEF_LRHB_CODE, "lrhb4");

        // Codes without hphi_en change nothing
        step(1'b0, 1'b0, DEF_SHS_CODE, 1'b0, 1'b0, "noen_shs");
        step(1'b0, 1'b0, DEF_CNT_CODE, 1'b1, 1'b0, "noen_shb");

        // Mid-sync reset
        line_begin("shb5");
        strobe(DEF_SHS_CODE, "shs5");
        step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, "midsync_reset");
        idle(2, "after_reset");
        line_begin("resync");

        // Lock-up count: sticky err in the ERR_EN build, ignored otherwise
        strobe(LOCKUP_CODE, "lockup");
        for (int l = 0; l < 3; l++) begin
            line_begin("err_line");
            strobe(DEF_SHS_CODE, "err_shs");
            strobe(DEF_RHS_CODE, "err_rhs");
            strobe(DEF_RHB_CODE, "err_rhb");
        end
        step(1'b1, 1'b0, 6'h00, 1'b0, 1'b0, "err_reset");
        idle(1, "end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
